// File: rtl/seq_counter_fsm_pkg.sv
// Shared constants and helpers for the programmable sequence counter.
// Latency: none (package only). Backpressure: not applicable.
package seq_counter_fsm_pkg;

  // Default table contents: entries 0..3 = 0, 2, 5, 7.
  localparam logic [31:0] DEFAULT_SEQ = {8'd7, 8'd5, 8'd2, 8'd0};

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Index width never collapses to zero bits, even for a 1-entry table.
  function automatic int idx_width(input int depth);
    return (clog2(depth) > 1) ? clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/seq_counter_fsm_if.sv
// Control, table-write and observation signals of the sequence counter.
// Latency: none (wiring only). Backpressure: none, every strobe is taken on its edge.
interface seq_counter_fsm_if
  import seq_counter_fsm_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);

  localparam int AW = idx_width(DEPTH);
  localparam int LW = clog2(DEPTH + 1);

  logic             en;
  logic             dir;
  logic             clr;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             len_we;
  logic [LW-1:0]    len_data;
  logic [WIDTH-1:0] count;
  logic [AW-1:0]    step_idx;
  logic             wrap;

  modport master (
    output en, dir, clr, wr_en, wr_addr, wr_data, len_we, len_data,
    input  count, step_idx, wrap
  );

  modport slave (
    input  en, dir, clr, wr_en, wr_addr, wr_data, len_we, len_data,
    output count, step_idx, wrap
  );

endinterface

// File: rtl/seq_counter_fsm_table.sv
// DEPTH x WIDTH register file: one synchronous write port, one combinational read port.
// Latency: write visible on the read port after the write edge. Backpressure: none.
module seq_table
  import seq_counter_fsm_pkg::*;
#(
  parameter int                     WIDTH    = 8,
  parameter int                     DEPTH    = 4,
  parameter logic [DEPTH*WIDTH-1:0] INIT_SEQ = DEFAULT_SEQ,
  parameter int                     AW       = idx_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Reset reloads the whole table, so programmed values do not survive rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= INIT_SEQ[i*WIDTH +: WIDTH];
      end
    end else if (wr_en && (int'(wr_addr) < DEPTH)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    if (int'(rd_addr) < DEPTH) begin
      rd_data = mem[rd_addr];
    end
  end

endmodule

// File: rtl/seq_counter_fsm.sv
// Moore sequence counter: step index walks a programmable table, count = table[step].
// Latency: count/step/wrap update one edge after en/clr/len_we. Backpressure: none.
module seq_counter_fsm
  import seq_counter_fsm_pkg::*;
#(
  parameter int                     WIDTH    = 8,
  parameter int                     DEPTH    = 4,
  parameter logic [DEPTH*WIDTH-1:0] INIT_SEQ = DEFAULT_SEQ
) (
  input  logic             clk,
  input  logic             rst,
  seq_counter_fsm_if.slave bus
);

  localparam int             AW      = idx_width(DEPTH);
  localparam int             LW      = clog2(DEPTH + 1);
  localparam logic [LW-1:0]  LEN_MAX = LW'(DEPTH);
  localparam logic [LW-1:0]  ONE     = LW'(1);

  logic [AW-1:0]    step_q;
  logic [AW-1:0]    step_d;
  logic [LW-1:0]    len_q;
  logic [LW-1:0]    len_d;
  logic             wrap_q;
  logic             wrap_d;
  logic [LW-1:0]    step_w;
  logic [LW-1:0]    last_step;
  logic [LW-1:0]    step_nxt;
  logic [WIDTH-1:0] rd_data;

  seq_table #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .INIT_SEQ (INIT_SEQ),
    .AW       (AW)
  ) u_table (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_addr (step_q),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q <= '0;
      len_q  <= LEN_MAX;
      wrap_q <= 1'b0;
    end else begin
      step_q <= step_d;
      len_q  <= len_d;
      wrap_q <= wrap_d;
    end
  end

  // Index math runs at LW bits so len-1 and the clamp compare never alias mod 2^AW.
  always_comb begin
    len_d     = len_q;
    wrap_d    = 1'b0;
    step_w    = LW'(step_q);
    last_step = len_q - ONE;
    step_nxt  = step_w;

    if (bus.len_we && (bus.len_data != '0)) begin
      len_d = (bus.len_data > LEN_MAX) ? LEN_MAX : bus.len_data;
    end

    if (bus.clr) begin
      step_nxt = '0;
    end else if (bus.en) begin
      if (bus.dir == DIR_FWD) begin
        if (step_w == last_step) begin
          step_nxt = '0;
          wrap_d   = 1'b1;
        end else begin
          step_nxt = step_w + ONE;
        end
      end else begin
        if (step_w == '0) begin
          step_nxt = last_step;
          wrap_d   = 1'b1;
        end else begin
          step_nxt = step_w - ONE;
        end
      end
    end

    // A shrinking length pulls an out-of-range step back to 0 without a wrap pulse.
    if (step_nxt >= len_d) begin
      step_nxt = '0;
    end

    step_d = step_nxt[AW-1:0];
  end

  always_comb begin
    bus.count    = rd_data;
    bus.step_idx = step_q;
    bus.wrap     = wrap_q;
  end

endmodule

// File: tb/tb_seq_counter_fsm.sv
// Directed bench for seq_counter_fsm with hand-computed expected count/step/wrap.
module tb_seq_counter_fsm;
  import seq_counter_fsm_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  seq_counter_fsm_if #(.WIDTH(8), .DEPTH(4)) bus ();

  seq_counter_fsm #(
    .WIDTH    (8),
    .DEPTH    (4),
    .INIT_SEQ (DEFAULT_SEQ)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int fwd_cnt [8] = '{2, 5, 7, 0, 2, 5, 7, 0};
  int fwd_stp [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
  int fwd_wrp [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
  int rev_cnt [8] = '{7, 5, 2, 0, 7, 5, 7, 0};
  int rev_stp [8] = '{3, 2, 1, 0, 3, 2, 3, 0};
  int rev_wrp [8] = '{1, 0, 0, 0, 1, 0, 0, 1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic exp_state(input string tag, input int c, input int s, input int w);
    chk({tag, ".count"}, 32'(bus.count), c);
    chk({tag, ".step"}, 32'(bus.step_idx), s);
    chk({tag, ".wrap"}, 32'(bus.wrap), w);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    bus.en       = 1'b0;
    bus.dir      = DIR_FWD;
    bus.clr      = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.len_we   = 1'b0;
    bus.len_data = '0;
    #2;
    exp_state("reset", 0, 0, 0);
    tick();
    rst = 1'b0;

    // Forward walk over the default table, two full laps.
    bus.en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_state($sformatf("fwd%0d", i), fwd_cnt[i], fwd_stp[i], fwd_wrp[i]);
    end

    // Async reset clears a pending wrap, then reverse walk with a direction flip.
    bus.en = 1'b0;
    rst = 1'b1;
    #2;
    exp_state("rst_async1", 0, 0, 0);
    rst = 1'b0;
    bus.dir = DIR_REV;
    bus.en  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 6) bus.dir = DIR_FWD;
      tick();
      exp_state($sformatf("rev%0d", i), rev_cnt[i], rev_stp[i], rev_wrp[i]);
    end

    // Program table {10,20,30,40} with the counter parked at step 0.
    bus.en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 2'(i);
      bus.wr_data = 8'((i + 1) * 10);
      tick();
      if (i == 0) exp_state("wr_cur", 10, 0, 0);
    end
    bus.wr_en    = 1'b0;
    bus.len_we   = 1'b1;
    bus.len_data = 3'd3;
    tick();
    bus.len_we = 1'b0;
    exp_state("len3", 10, 0, 0);
    bus.en = 1'b1;
    tick(); exp_state("l3_a", 20, 1, 0);
    tick(); exp_state("l3_b", 30, 2, 0);
    tick(); exp_state("l3_c", 10, 0, 1);
    tick(); exp_state("l3_d", 20, 1, 0);
    tick(); exp_state("l3_e", 30, 2, 0);
    tick(); exp_state("l3_f", 10, 0, 1);

    // len_data = 0 is ignored: the length stays 3.
    bus.len_we   = 1'b1;
    bus.len_data = 3'd0;
    tick(); exp_state("l0_a", 20, 1, 0);
    bus.len_we = 1'b0;
    tick(); exp_state("l0_b", 30, 2, 0);
    tick(); exp_state("l0_c", 10, 0, 1);

    // len_data = 7 clamps to 4; the step on that edge still uses length 3.
    bus.len_we   = 1'b1;
    bus.len_data = 3'd7;
    tick(); exp_state("l7_a", 20, 1, 0);
    bus.len_we = 1'b0;
    tick(); exp_state("l7_b", 30, 2, 0);
    tick(); exp_state("l7_c", 40, 3, 0);
    tick(); exp_state("l7_d", 10, 0, 1);

    // Shrinking length to 2 while at step 3 forces step 0, no wrap.
    tick(); tick(); tick();
    exp_state("at3", 40, 3, 0);
    bus.en       = 1'b0;
    bus.len_we   = 1'b1;
    bus.len_data = 3'd2;
    tick(); exp_state("shrink", 10, 0, 0);
    bus.len_we = 1'b0;
    bus.en     = 1'b1;
    tick(); exp_state("l2_a", 20, 1, 0);
    tick(); exp_state("l2_b", 10, 0, 1);
    tick(); exp_state("l2_c", 20, 1, 0);

    // Hold, then clear at the last step beats the would-be wrap.
    bus.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_state($sformatf("hold%0d", i), 20, 1, 0);
    end
    bus.clr = 1'b1;
    bus.en  = 1'b1;
    tick(); exp_state("clr", 10, 0, 0);
    bus.clr = 1'b0;
    bus.en  = 1'b0;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 2'd0;
    bus.wr_data = 8'd99;
    tick(); exp_state("wr_sel", 99, 0, 0);
    bus.wr_addr = 2'd1;
    bus.wr_data = 8'd55;
    bus.en      = 1'b1;
    tick(); exp_state("wr_step", 55, 1, 0);
    bus.wr_en = 1'b0;
    bus.en    = 1'b0;

    // Back to length 4, reach step 2, then reset between edges.
    bus.len_we   = 1'b1;
    bus.len_data = 3'd4;
    tick(); exp_state("len4", 55, 1, 0);
    bus.len_we = 1'b0;
    bus.en     = 1'b1;
    tick(); exp_state("pre_rst", 30, 2, 0);
    bus.en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    exp_state("rst_async2", 0, 0, 0);
    #2;
    rst = 1'b0;
    bus.en = 1'b1;
    tick(); exp_state("post_a", 2, 1, 0);
    tick(); exp_state("post_b", 5, 2, 0);
    tick(); exp_state("post_c", 7, 3, 0);
    tick(); exp_state("post_d", 0, 0, 1);
    bus.en = 1'b0;
    tick(); exp_state("post_e", 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seq_counter_fsm.md
Name: seq_counter_fsm

Overview:
Programmable sequence counter built as a Moore FSM. A step index walks a DEPTH-entry table of WIDTH-bit values, and the output count is the table entry at the current step.
- Generalises the fixed 0-2-5-7 counter with parametrised width and depth.
- Adds a runtime-writable table, a programmable sequence length, forward/reverse direction, enable, synchronous clear and a wrap pulse.
- Used as a pattern/address generator inside the FSMs library.

Parameters:
WIDTH, 8, bit width of each sequence value and of count.
DEPTH, 4, number of table entries (max sequence length); legal range >= 2.
INIT_SEQ, {8'd7,8'd5,8'd2,8'd0}, packed DEPTH*WIDTH reset contents; entry i sits at bits [i*WIDTH +: WIDTH].

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
en  in  1  advance one step this cycle.
dir  in  1  0 = forward (index+1), 1 = reverse (index-1).
clr  in  1  synchronous return to step 0.
wr_en  in  1  table write strobe.
wr_addr  in  AW=max(1,$clog2(DEPTH))  table entry to write.
wr_data  in  WIDTH  value to write.
len_we  in  1  sequence-length write strobe.
len_data  in  LW=$clog2(DEPTH+1)  new active length.
count  out  WIDTH  table[step_idx] (Moore output).
step_idx  out  AW  current step (FSM state).
wrap  out  1  one-cycle pulse on the edge where the sequence wraps.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values:
  - step_idx = 0, len = DEPTH, wrap = 0.
  - table = INIT_SEQ, so count = entry 0 (0 by default).
  - All of these take effect immediately on rst assertion, independent of clk.
- count is a combinational read of the registered table at the registered step_idx. It has no extra register stage and changes only after clock edges.
- Step update per clk edge, in priority order:
  1. clr = 1: step_idx <= 0, wrap <= 0. en is ignored.
  2. en = 1, dir = 0: if step_idx == len-1 then step_idx <= 0 and wrap <= 1; else step_idx <= step_idx+1 and wrap <= 0.
  3. en = 1, dir = 1: if step_idx == 0 then step_idx <= len-1 and wrap <= 1; else step_idx <= step_idx-1 and wrap <= 0.
  4. en = 0: step_idx holds, wrap <= 0.
- wrap is registered and high for exactly one cycle per wrap. Back-to-back wraps are possible when len = 1: wrap stays high while en = 1.
- Length write:
  - len_we = 1: len <= len_data, clamped to DEPTH if larger. len_data = 0 is ignored and len is unchanged.
  - The step update on the same edge uses the old len.
  - If the resulting step_idx >= new len, step_idx is forced to 0 on that edge, and wrap is not asserted by the forcing.
- Table write:
  - wr_en = 1 with wr_addr < DEPTH: table[wr_addr] <= wr_data.
  - wr_addr >= DEPTH: the write is ignored.
  - A write to the currently selected entry shows on count after that edge.
  - Writes are independent of en, clr and len_we; all may occur in the same cycle.
- Reset mid-sequence: everything returns to reset values, including table contents and len. Programmed values are lost.
- Arithmetic: index math is modulo len, never modulo 2^AW. Values are stored verbatim; there is no arithmetic on count.

Decomposition:
- Shared package/include holds:
  - the default sequence constant (0,2,5,7);
  - a clog2 helper function;
  - the direction encodings DIR_FWD = 1'b0 and DIR_REV = 1'b1.
- One natural sub-module, seq_table: DEPTH x WIDTH register file with asynchronous reset to INIT_SEQ, one synchronous write port and one combinational read port.
- The step FSM and length register stay in seq_counter_fsm.

Test Plan:
- Defaults, rst released, en = 1, dir = 0 for 9 cycles -> count 0,2,5,7,0,2,5,7,0; wrap high only on the 7->0 edges.
- en = 1, dir = 1 from reset -> count 0,7,5,2,0,7; wrap on the 0->7 edges only. Toggle dir at step 2 -> sequence reverses on the next edge.
- Write table = {10,20,30,40}, then len_we with len_data = 3, run forward -> 10,20,30,10,... Then len_data = 0 -> len unchanged. Then len_data = 7 -> clamps to 4, and 40 reappears.
- At step 3, set len = 2 -> step_idx forced to 0, count = table[0], wrap = 0.
- Hold en = 0 for 5 cycles mid-sequence -> count stable. Assert clr together with en = 1 -> step_idx = 0 next edge with no wrap. Write to the current entry -> new value shows on count after the edge.
- Assert rst asynchronously between edges at step 2 after custom writes -> count = 0 immediately. After release, the sequence is 0,2,5,7 again with len = 4.
